// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller:
//   - XLEN   : core data width (also the width of the stall counter)
//   - REG_W  : architectural register index width
//   - ST_*   : stage indices into the per-stage stall/flush vectors
//   - ctrl_state_e : hazard controller FSM states
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam int ST_IF  = 0;
    localparam int ST_ID  = 1;
    localparam int ST_EX  = 2;
    localparam int ST_MEM = 3;
    localparam int ST_WB  = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MDIV    = 2'd1,
        TRAPGAP = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_mcyc_timer.sv
// ---------------------------------------------------------------------------
// mcyc_timer
// Loadable down-counter used for multi-cycle occupancy and trap gap timing.
// Ports:
//   clk, grst    : clock, asynchronous active-high reset (count -> 0)
//   load_i       : load load_val_i this cycle (wins over decrement)
//   load_val_i   : value to load
//   dec_i        : decrement this cycle; the count sticks at zero
//   zero_o       : registered count is zero
// ---------------------------------------------------------------------------
module mcyc_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         grst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush generator for the 5-stage pipeline register buffers
// (IF=0 ID=1 EX=2 MEM=3 WB=4). Resolves load-use hazards, EX redirects,
// data/instruction memory wait states, MUL/DIV occupancy of EX and trap
// entry, and counts IF-stall cycles for the performance CSRs.
// Ports:
//   clk, grst               : clock, asynchronous active-high reset
//   id_rs1/id_rs2           : ID source registers, id_use_rs1/2 = valid
//   ex_is_load, ex_rd       : EX holds a load writing ex_rd
//   ex_mdiv_start, ex_is_div: EX starts a MUL (0) or DIV/REM (1) this cycle
//   ex_redirect             : EX resolved a mispredicted branch/jump
//   imem_busy, dmem_busy    : fetch / MEM access not complete
//   trap_req                : exception/interrupt committed at WB
//   stall[i], flush[i]      : hold / zero stage register i (same cycle)
//   stall_cnt               : saturating count of cycles with stall[IF]
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int               MRLen         = 6,
    parameter int               MUL_CYCLES    = 3,
    parameter int               DIV_CYCLES    = 33,
    parameter int               TRAP_GAP      = 2,
    // Reset value of stall_cnt; left at zero in the core, a value near the
    // top lets saturation be exercised without billions of cycles.
    parameter logic [XLEN-1:0]  STALL_CNT_RST = '0
) (
    input  logic             clk,
    input  logic             grst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mdiv_start,
    input  logic             ex_is_div,
    input  logic             ex_redirect,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             trap_req,
    output logic             stall [MRLen-2:0],
    output logic             flush [MRLen-2:0],
    output logic [XLEN-1:0]  stall_cnt
);

    localparam int NS    = MRLen - 1;
    localparam int M_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int MW    = $clog2(M_MAX) + 1;
    localparam int GW    = $clog2(TRAP_GAP) + 1;

    ctrl_state_e      state_q, state_d;
    logic             lu_done_q, lu_done_d;
    logic [XLEN-1:0]  stall_cnt_q, stall_cnt_d;

    logic             m_load, m_zero;
    logic [MW-1:0]    m_load_val;
    logic             g_load, g_zero;

    logic [MW-1:0]    mdiv_len;
    logic             mdiv_issue;
    logic             mdiv_busy;
    logic             lu_hit;
    logic [NS-1:0]    stall_v, flush_v;

    // Remaining EX occupancy after the issuing cycle; zero means the op
    // finishes in its first cycle and never holds the pipe.
    assign mdiv_len   = ex_is_div ? MW'(DIV_CYCLES - 1) : MW'(MUL_CYCLES - 1);
    assign mdiv_issue = (state_q == RUN) && ex_mdiv_start && (mdiv_len != '0);
    // The issuing cycle is already an occupied EX cycle, so it stalls too.
    assign mdiv_busy  = mdiv_issue || ((state_q == MDIV) && !m_zero);

    // x0 is hardwired zero, so a load to it never creates a dependency.
    // lu_done_q suppresses a second stall for the same load.
    assign lu_hit = ex_is_load && (ex_rd != '0) && !lu_done_q &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    // ---------------- stall / flush priority ----------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        stall_v   = '0;
        flush_v   = '0;
        lu_done_d = 1'b0;
        if (trap_req) begin
            flush_v[ST_MEM:ST_IF] = '1;
        end else if (state_q == TRAPGAP) begin
            stall_v[ST_IF] = 1'b1;
        end else if (ex_redirect) begin
            // ID is squashed, so any pending load-use is moot.
            flush_v[ST_ID:ST_IF] = '1;
            if (dmem_busy) begin
                stall_v[ST_MEM:ST_EX] = '1;
            end
        end else begin
            if (dmem_busy) begin
                stall_v[ST_MEM:ST_IF] = '1;
            end else if (mdiv_busy) begin
                stall_v[ST_EX:ST_IF] = '1;
            end else if (lu_hit) begin
                stall_v[ST_ID:ST_IF] = '1;
                lu_done_d            = 1'b1;
            end
            if (imem_busy) begin
                stall_v[ST_IF] = 1'b1;
            end
        end
        // Nothing downstream back-pressures WB.
        stall_v[ST_WB] = 1'b0;
    end

    // While reset is held every stage register is zeroed, none is held.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            stall[i] = grst ? 1'b0 : stall_v[i];
            flush[i] = grst ? 1'b1 : flush_v[i];
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d    = state_q;
        m_load     = 1'b0;
        m_load_val = mdiv_len;
        g_load     = 1'b0;
        if (trap_req) begin
            // Trap entry aborts any MUL/DIV in flight.
            state_d    = TRAPGAP;
            g_load     = 1'b1;
            m_load     = 1'b1;
            m_load_val = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mdiv_issue) begin
                        state_d = MDIV;
                        m_load  = 1'b1;
                    end
                end
                MDIV: begin
                    if (m_zero) state_d = RUN;
                end
                TRAPGAP: begin
                    if (g_zero) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    mcyc_timer #(.W(MW)) u_mcnt (
        .clk        (clk),
        .grst       (grst),
        .load_i     (m_load),
        .load_val_i (m_load_val),
        .dec_i      (state_q == MDIV),
        .zero_o     (m_zero)
    );

    mcyc_timer #(.W(GW)) u_gapcnt (
        .clk        (clk),
        .grst       (grst),
        .load_i     (g_load),
        .load_val_i (GW'(TRAP_GAP - 1)),
        .dec_i      (state_q == TRAPGAP),
        .zero_o     (g_zero)
    );

    // ---------------- perf counter ----------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_v[ST_IF] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            state_q     <= RUN;
            lu_done_q   <= 1'b0;
            stall_cnt_q <= STALL_CNT_RST;
        end else begin
            state_q     <= state_d;
            lu_done_q   <= lu_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    // A new MUL/DIV cannot issue while EX is still occupied by one.
    a_no_mdiv_restart: assert property (@(posedge clk) disable iff (grst)
        !((state_q == MDIV) && ex_mdiv_start));

endmodule
